// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace-debug packet path.
package trdb_pkg;

    localparam int TRDB_PACKET_W = 128;
    localparam int TRDB_SLICE_W  = 32;
    localparam int TRDB_NBEATS_W = $clog2(TRDB_PACKET_W / TRDB_SLICE_W + 1);

    // Queue entry for the default configuration; payload is already tail-masked.
    typedef struct packed {
        logic [TRDB_PACKET_W-1:0] payload;
        logic [TRDB_NBEATS_W-1:0] nbeats;
    } trdb_qentry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } trdb_slicer_state_t;

    function automatic int trdb_ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/trdb_packet_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra bit to tell full from empty.
module trdb_packet_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign level   = LW'(wptr_q - rptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/trdb_packet_slicer.sv
// Queues variable-length trace packets and serialises each into SLICE_W-wide
// valid/ready beats, LSB first, with a last-beat flag and a saturating drop count.
module trdb_packet_slicer
    import trdb_pkg::*;
#(
    parameter int PACKET_W     = TRDB_PACKET_W,
    parameter int SLICE_W      = TRDB_SLICE_W,
    parameter int DEPTH        = 4,
    parameter int LEN_W        = $clog2(PACKET_W + 1),
    parameter bit DROP_ON_FULL = 1'b0,
    parameter int CNT_W        = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [PACKET_W-1:0]        packet_bits_i,
    input  logic [LEN_W-1:0]           packet_len_i,
    input  logic                       packet_valid_i,
    output logic                       packet_ready_o,
    output logic [SLICE_W-1:0]         slice_o,
    output logic                       slice_valid_o,
    input  logic                       slice_ready_i,
    output logic                       slice_last_o,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level_o,
    output logic [CNT_W-1:0]           drop_cnt_o,
    output logic                       busy_o
);

    localparam int NBEATS = trdb_ceil_div(PACKET_W, SLICE_W);
    localparam int NB_W   = $clog2(NBEATS + 1);

    typedef struct packed {
        logic [PACKET_W-1:0] payload;
        logic [NB_W-1:0]     nbeats;
    } qentry_t;

    qentry_t             in_entry;
    qentry_t             head_entry;
    logic [LEN_W-1:0]    len_eff;
    logic [LEN_W:0]      len_round;
    logic [PACKET_W-1:0] len_mask;
    logic                len_zero;
    logic                accept;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                drop_evt;

    trdb_slicer_state_t  state_q, state_d;
    logic [PACKET_W-1:0] shift_q, shift_d;
    logic [NB_W-1:0]     beat_q, beat_d;
    logic [NB_W-1:0]     nbeats_q, nbeats_d;
    logic [CNT_W-1:0]    drop_cnt_q;
    logic                is_last;

    // Clamp the length, round up to whole beats and zero everything above L at push time.
    assign len_eff   = (packet_len_i > LEN_W'(PACKET_W)) ? LEN_W'(PACKET_W) : packet_len_i;
    assign len_round = {1'b0, len_eff} + (LEN_W + 1)'(SLICE_W - 1);
    assign len_mask  = ~({PACKET_W{1'b1}} << len_eff);
    assign len_zero  = (len_eff == '0);

    assign in_entry.payload = packet_bits_i & len_mask;
    assign in_entry.nbeats  = NB_W'(len_round / (LEN_W + 1)'(SLICE_W));

    // Full is judged on the start-of-cycle level, so a same-cycle pop never frees a slot.
    assign packet_ready_o = !rst_i && (DROP_ON_FULL || !fifo_full);
    assign accept         = packet_valid_i && packet_ready_o;
    assign fifo_push      = accept && !flush_i && !len_zero && !fifo_full;
    assign drop_evt       = accept && !flush_i && (len_zero || fifo_full);

    trdb_packet_fifo #(
        .WIDTH ($bits(qentry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (fifo_push),
        .wdata (in_entry),
        .pop   (fifo_pop),
        .rdata (head_entry),
        .flush (flush_i),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level_o)
    );

    assign is_last = (state_q == ST_SEND) && (beat_q == nbeats_q - NB_W'(1));

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        beat_d   = beat_q;
        nbeats_d = nbeats_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = head_entry.payload;
                    nbeats_d = head_entry.nbeats;
                    beat_d   = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (slice_ready_i) begin
                    if (is_last) begin
                        // Back-to-back: the next packet loads on the last beat's handshake.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = head_entry.payload;
                            nbeats_d = head_entry.nbeats;
                            beat_d   = '0;
                        end else begin
                            shift_d = '0;
                            beat_d  = '0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        shift_d = shift_q >> SLICE_W;
                        beat_d  = beat_q + NB_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            beat_q   <= '0;
            nbeats_q <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            beat_q   <= beat_d;
            nbeats_q <= nbeats_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else if (drop_evt && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    assign slice_o       = shift_q[SLICE_W-1:0];
    assign slice_valid_o = (state_q == ST_SEND);
    assign slice_last_o  = is_last;
    assign drop_cnt_o    = drop_cnt_q;
    assign busy_o        = (state_q == ST_SEND) || !fifo_empty;

endmodule

// File: tb/tb_trdb_packet_slicer.sv
// Directed bench for trdb_packet_slicer: one backpressure instance and one drop-on-full instance.
module tb_trdb_packet_slicer;

    localparam int PW  = 128;
    localparam int SW  = 32;
    localparam int LW  = 8;
    localparam int CW  = 16;
    localparam int LVW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] bits;
    logic [LW-1:0] len;
    logic          pvalid;
    logic          sready;
    logic          flush;

    logic          pready0, svalid0, slast0, busy0;
    logic [SW-1:0] slice0;
    logic [LVW-1:0] level0;
    logic [CW-1:0] drop0;
    logic          pready1, svalid1, slast1, busy1;
    logic [SW-1:0] slice1;
    logic [LVW-1:0] level1;
    logic [CW-1:0] drop1;

    logic          mon_sel;
    logic          m_valid, m_last, m_ready;
    logic [SW-1:0] m_slice;

    logic [SW:0]   exp_q[$];
    int            n_vec;
    int            n_bad;
    logic          acc_r;

    always #5 clk = ~clk;

    trdb_packet_slicer #(.DROP_ON_FULL(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .packet_bits_i(bits), .packet_len_i(len),
        .packet_valid_i(pvalid), .packet_ready_o(pready0), .slice_o(slice0),
        .slice_valid_o(svalid0), .slice_ready_i(sready), .slice_last_o(slast0),
        .flush_i(flush), .fifo_level_o(level0), .drop_cnt_o(drop0), .busy_o(busy0)
    );

    trdb_packet_slicer #(.DROP_ON_FULL(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .packet_bits_i(bits), .packet_len_i(len),
        .packet_valid_i(pvalid), .packet_ready_o(pready1), .slice_o(slice1),
        .slice_valid_o(svalid1), .slice_ready_i(sready), .slice_last_o(slast1),
        .flush_i(flush), .fifo_level_o(level1), .drop_cnt_o(drop1), .busy_o(busy1)
    );

    assign m_valid = mon_sel ? svalid1 : svalid0;
    assign m_last  = mon_sel ? slast1  : slast0;
    assign m_slice = mon_sel ? slice1  : slice0;
    assign m_ready = mon_sel ? pready1 : pready0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted beat of the monitored instance must match the queue head.
    always @(negedge clk) begin
        if (!rst && m_valid && sready) begin
            if (exp_q.size() == 0) chk("extra_beat", 64'(exp_q.size()), 64'd1);
            else                   chk("beat", 64'({m_last, m_slice}), 64'(exp_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic drive_pkt(input logic [PW-1:0] b, input logic [LW-1:0] l);
        pvalid = 1'b1;
        bits   = b;
        len    = l;
        @(negedge clk) acc_r = m_ready;
        @(posedge clk);
        #1;
        pvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && (exp_q.size() != 0 || busy0 || busy1); i++) tick(1);
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        rst = 1'b1; bits = '0; len = '0; pvalid = 1'b0; sready = 1'b0; flush = 1'b0;
        mon_sel = 1'b0; acc_r = 1'b0;
        tick(2);
        chk("rst_pready", 64'(pready0), 64'd0);
        rst = 1'b0;
        chk("rst_slice", 64'(slice0), 64'd0);
        chk("rst_valid", 64'(svalid0), 64'd0);
        chk("rst_last",  64'(slast0), 64'd0);
        chk("rst_level", 64'(level0), 64'd0);
        chk("rst_drop",  64'(drop0), 64'd0);
        chk("rst_busy",  64'(busy0), 64'd0);

        // Single 70-bit packet: three beats, tail of the last beat masked above bit 69.
        sready = 1'b1;
        exp_q.push_back({1'b0, 32'h7654_3210});
        exp_q.push_back({1'b0, 32'hFEDC_BA98});
        exp_q.push_back({1'b1, 32'h0000_002F});
        drive_pkt(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 8'd70);
        chk("t1_accept", 64'(acc_r), 64'd1);
        chk("t1_lat1_valid", 64'(svalid0), 64'd0);
        chk("t1_lat1_level", 64'(level0), 64'd1);
        tick(1);
        chk("t1_lat2_valid", 64'(svalid0), 64'd1);
        chk("t1_lat2_slice", 64'(slice0), 64'h7654_3210);
        drain("t1_drain");
        chk("t1_drop", 64'(drop0), 64'd0);

        // Four single-beat packets back to back: no bubble between them.
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 32'hC0DE_0000 + 32'(k)});
        drive_pkt(128'(32'hC0DE_0000), 8'd32);
        drive_pkt(128'(32'hC0DE_0001), 8'd32);
        chk("t2_v0", 64'(svalid0), 64'd1);
        drive_pkt(128'(32'hC0DE_0002), 8'd32);
        chk("t2_v1", 64'(svalid0), 64'd1);
        drive_pkt(128'(32'hC0DE_0003), 8'd32);
        chk("t2_v2", 64'(svalid0), 64'd1);
        tick(1);
        chk("t2_v3", 64'(svalid0), 64'd1);
        tick(1);
        chk("t2_idle_valid", 64'(svalid0), 64'd0);
        chk("t2_idle_busy", 64'(busy0), 64'd0);
        drain("t2_drain");

        // Backpressure mode: five accepted (four queued plus one loaded), sixth refused.
        do_reset();
        sready = 1'b0;
        for (int k = 0; k < 5; k++) exp_q.push_back({1'b1, 32'hA000_0000 + 32'(k)});
        for (int k = 0; k < 6; k++) begin
            drive_pkt(128'(32'hA000_0000 + 32'(k)), 8'd32);
            chk($sformatf("t3_accept%0d", k), 64'(acc_r), (k < 5) ? 64'd1 : 64'd0);
        end
        chk("t3_level", 64'(level0), 64'd4);
        sready = 1'b1;
        drain("t3_drain");
        chk("t3_drop", 64'(drop0), 64'd0);

        // Drop-on-full mode: always ready, three of eight dropped, first five emitted.
        do_reset();
        mon_sel = 1'b1;
        sready  = 1'b0;
        for (int k = 0; k < 5; k++) exp_q.push_back({1'b1, 32'hB000_0000 + 32'(k)});
        for (int k = 0; k < 8; k++) begin
            drive_pkt(128'(32'hB000_0000 + 32'(k)), 8'd32);
            chk($sformatf("t4_accept%0d", k), 64'(acc_r), 64'd1);
        end
        chk("t4_drop", 64'(drop1), 64'd3);
        sready = 1'b1;
        drain("t4_drain");
        chk("t4_drop_end", 64'(drop1), 64'd3);
        chk("t4_level_end", 64'(level1), 64'd0);
        mon_sel = 1'b0;

        // Flush mid-packet with three queued: current packet completes, queue and same-cycle offer discarded.
        do_reset();
        sready = 1'b0;
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), 32'h1000_0000 + 32'(k)});
        for (int p = 0; p < 4; p++) begin
            drive_pkt({32'h1000_0003 + 32'(p << 8), 32'h1000_0002 + 32'(p << 8),
                       32'h1000_0001 + 32'(p << 8), 32'h1000_0000 + 32'(p << 8)}, 8'd128);
        end
        chk("t5_level_pre", 64'(level0), 64'd3);
        sready = 1'b1;
        tick(1);
        flush  = 1'b1;
        pvalid = 1'b1;
        bits   = 128'(32'hDEAD_BEEF);
        len    = 8'd32;
        tick(1);
        flush  = 1'b0;
        pvalid = 1'b0;
        chk("t5_level_post", 64'(level0), 64'd0);
        chk("t5_drop", 64'(drop0), 64'd0);
        chk("t5_busy_mid", 64'(busy0), 64'd1);
        drain("t5_drain");
        chk("t5_busy_end", 64'(busy0), 64'd0);
        chk("t5_valid_end", 64'(svalid0), 64'd0);

        // Reset on beat 2 of 4 aborts the packet; a zero-length offer afterwards is only counted.
        do_reset();
        sready = 1'b0;
        drive_pkt(128'(32'h5555_5555), 8'd0);
        chk("t6_drop_pre", 64'(drop0), 64'd1);
        chk("t6_len0_level", 64'(level0), 64'd0);
        exp_q.push_back({1'b0, 32'h2000_0000});
        exp_q.push_back({1'b0, 32'h2000_0001});
        drive_pkt({32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000}, 8'd128);
        drive_pkt(128'(32'h3000_0000), 8'd32);
        chk("t6_level_pre", 64'(level0), 64'd1);
        sready = 1'b1;
        tick(2);
        chk("t6_beat2", 64'(slice0), 64'h2000_0002);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_rst_valid", 64'(svalid0), 64'd0);
        chk("t6_rst_level", 64'(level0), 64'd0);
        chk("t6_rst_drop",  64'(drop0), 64'd0);
        chk("t6_queue", 64'(exp_q.size()), 64'd0);
        drive_pkt(128'(32'h7777_7777), 8'd0);
        tick(3);
        chk("t6_len0_drop", 64'(drop0), 64'd1);
        chk("t6_len0_valid", 64'(svalid0), 64'd0);
        chk("t6_len0_busy", 64'(busy0), 64'd0);

        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
